uart_rx_cfg: RTL and testbench

Configurable UART receiver, the successor to the fixed 8N1 receiver in the peripheral library. It adds runtime selection of 5–8 data bits, optional even/odd parity and 1 or 2 stop bits. It also reports per-character parity and framing errors, detects break conditions, and buffers received characters in a first-word-fall-through FIFO with a valid/ready pop interface. It sits between the pad-side serial input and the UART register block.

---
 rtl/uart_rx_cfg.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5-8 data bits, optional even/odd
// parity, 1 or 2 stop bits) with parity/framing error flags, break detection
// and a first-word-fall-through receive FIFO.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   rx_i                  asynchronous serial input, idles high
//   clks_per_bit_i        clock cycles per bit (>= 4)
//   data_bits_i           00=5, 01=6, 10=7, 11=8 data bits
//   parity_en_i           parity bit present
//   parity_odd_i          1 = odd parity, 0 = even
//   stop2_i               check two stop bits
//   rx_data_o             head-of-FIFO character, right-aligned
//   rx_perr_o, rx_ferr_o  head-of-FIFO parity / framing error flags
//   rx_valid_o            FIFO not empty
//   rx_ready_i            pop head when rx_valid_o & rx_ready_i
//   overrun_o             one-cycle pulse: character dropped, FIFO full
//   break_o               one-cycle pulse: break detected
//   fifo_count_o          FIFO occupancy
module uart_rx_cfg #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  input  logic [CNT_W-1:0]              clks_per_bit_i,
  input  logic [1:0]                    data_bits_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          stop2_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_perr_o,
  output logic                          rx_ferr_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic                          overrun_o,
  output logic                          break_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 10;  // {data[7:0], perr, ferr}

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HIGH
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_sync;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [2:0]        r_idx, w_idx_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              r_perr, w_perr_nxt;
  logic              r_zero, w_zero_nxt;   // every bit sampled so far was 0
  logic [CNT_W-1:0]  r_cpb;
  logic [1:0]        r_dbits;
  logic              r_pen, r_podd, r_stop2;
  logic              r_break, r_overrun;
  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr, r_rd;
  logic [CW-1:0]     r_count;

  logic              w_rxs, w_latch, w_push, w_push_ferr, w_brk;
  logic [CNT_W-1:0]  w_half, w_last;
  logic [2:0]        w_last_idx;
  logic              w_full, w_empty, w_pop, w_wr_en;
  logic [EW-1:0]     w_head;

  assign w_rxs      = r_sync[1];
  assign w_last     = r_cpb - CNT_W'(1);
  assign w_half     = w_last >> 1;
  assign w_last_idx = 3'(r_dbits) + 3'd4;

  // Next-state and datapath updates for the receive FSM
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_zero_nxt  = r_zero;
    w_latch     = 1'b0;
    w_push      = 1'b0;
    w_push_ferr = 1'b0;
    w_brk       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_shift_nxt = '0;
        w_perr_nxt  = 1'b0;
        w_zero_nxt  = 1'b1;
        if (!w_rxs) begin
          w_latch     = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == w_half) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rxs ? S_IDLE : S_DATA;  // high at mid-start: glitch
        end
      end
      S_DATA: begin
        if (r_cnt == w_last) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_rxs;
          w_zero_nxt         = r_zero & ~w_rxs;
          if (r_idx == w_last_idx) w_state_nxt = r_pen ? S_PARITY : S_STOP1;
          else                     w_idx_nxt   = r_idx + 3'd1;
        end
      end
      S_PARITY: begin
        if (r_cnt == w_last) begin
          w_cnt_nxt   = '0;
          w_perr_nxt  = (^r_shift) ^ w_rxs ^ r_podd;
          w_zero_nxt  = r_zero & ~w_rxs;
          w_state_nxt = S_STOP1;
        end
      end
      S_STOP1: begin
        if (r_cnt == w_last) begin
          w_cnt_nxt = '0;
          if (r_stop2 && w_rxs) begin
            w_state_nxt = S_STOP2;
          end else begin
            w_push      = 1'b1;
            w_push_ferr = ~w_rxs;
            w_brk       = r_zero & ~w_rxs;
            w_state_nxt = w_rxs ? S_IDLE : S_WAIT_HIGH;
          end
        end
      end
      S_STOP2: begin
        if (r_cnt == w_last) begin
          w_cnt_nxt   = '0;
          w_push      = 1'b1;
          w_push_ferr = ~w_rxs;
          w_state_nxt = w_rxs ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        w_cnt_nxt = '0;
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = ~w_empty & rx_ready_i;
  assign w_wr_en = w_push & (~w_full | w_pop);

  // State, shadow config, synchroniser, FIFO pointers and pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_sync    <= 2'b11;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_zero    <= 1'b1;
      r_cpb     <= '0;
      r_dbits   <= '0;
      r_pen     <= 1'b0;
      r_podd    <= 1'b0;
      r_stop2   <= 1'b0;
      r_break   <= 1'b0;
      r_overrun <= 1'b0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sync    <= {r_sync[0], rx_i};
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_perr    <= w_perr_nxt;
      r_zero    <= w_zero_nxt;
      if (w_latch) begin
        r_cpb   <= clks_per_bit_i;
        r_dbits <= data_bits_i;
        r_pen   <= parity_en_i;
        r_podd  <= parity_odd_i;
        r_stop2 <= stop2_i;
      end
      r_break   <= w_brk;
      r_overrun <= w_push & w_full & ~w_pop;
      if (w_wr_en) r_wr <= r_wr + AW'(1);
      if (w_pop)   r_rd <= r_rd + AW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are qualified by the occupancy count
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[r_wr] <= {r_shift, r_perr, w_push_ferr};
  end

  assign w_head       = r_mem[r_rd];
  assign rx_valid_o   = ~w_empty;
  assign rx_data_o    = w_empty ? 8'h00 : w_head[9:2];
  assign rx_perr_o    = ~w_empty & w_head[1];
  assign rx_ferr_o    = ~w_empty & w_head[0];
  assign overrun_o    = r_overrun;
  assign break_o      = r_break;
  assign fifo_count_o = r_count;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: frame table plus hand-written corner sequences,
// checked against an expected-entry queue popped as the FIFO is drained.
module tb_uart_rx_cfg;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             rx_i  = 1'b1;
  logic [CNT_W-1:0] clks_per_bit_i = CNT_W'(16);
  logic [1:0]       data_bits_i  = 2'd3;
  logic             parity_en_i  = 1'b0;
  logic             parity_odd_i = 1'b0;
  logic             stop2_i      = 1'b0;
  logic             rx_ready_i   = 1'b0;
  logic [7:0]       rx_data_o;
  logic             rx_perr_o, rx_ferr_o, rx_valid_o, overrun_o, break_o;
  logic [CW-1:0]    fifo_count_o;

  int checks   = 0;
  int failures = 0;
  int brk_cnt  = 0;
  int ovr_cnt  = 0;
  logic [9:0] exp_q [$];

  uart_rx_cfg #(.CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i),
    .clks_per_bit_i(clks_per_bit_i), .data_bits_i(data_bits_i),
    .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i), .stop2_i(stop2_i),
    .rx_data_o(rx_data_o), .rx_perr_o(rx_perr_o), .rx_ferr_o(rx_ferr_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .overrun_o(overrun_o), .break_o(break_o), .fifo_count_o(fifo_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every popped entry with the oldest expected one
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (break_o)   brk_cnt++;
      if (overrun_o) ovr_cnt++;
      if (rx_valid_o && rx_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_entry actual=0x%0h required=none",
                   {rx_data_o, rx_perr_o, rx_ferr_o});
        end else begin
          check("entry", 32'({rx_data_o, rx_perr_o, rx_ferr_o}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_i = b;
    cycles(n);
  endtask

  task automatic set_cfg(input int cpb, input logic [1:0] db, input logic pen,
                         input logic podd, input logic st2);
    clks_per_bit_i = CNT_W'(cpb);
    data_bits_i    = db;
    parity_en_i    = pen;
    parity_odd_i   = podd;
    stop2_i        = st2;
  endtask

  // Full frame plus 2-bit idle gap; live config is scrambled after the start bit
  task automatic send_frame(input int cpb, input logic [1:0] db, input logic pen,
                            input logic podd, input logic st2, input logic [7:0] d,
                            input logic pb, input logic s1, input logic s2);
    int n;
    n = 5 + int'(db);
    set_cfg(cpb, db, pen, podd, st2);
    drive_bit(1'b0, cpb);
    set_cfg(cpb + 3, ~db, ~pen, ~podd, ~st2);
    for (int i = 0; i < n; i++) drive_bit(d[i], cpb);
    if (pen) drive_bit(pb, cpb);
    drive_bit(s1, cpb);
    if (st2) drive_bit(s2, cpb);
    drive_bit(1'b1, 2 * cpb);
  endtask

  typedef struct {
    int         cpb;
    logic [1:0] db;
    logic       pen, podd, st2;
    logic [7:0] d;
    logic       pb, s1, s2;
    logic [7:0] ed;
    logic       ep, ef;
  } vec_t;

  vec_t vecs [10];
  int   b0, o0;

  initial begin
    vecs[0] = '{16, 2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{16, 2'd2, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{16, 2'd2, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[3] = '{16, 2'd0, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 1'b1, 1'b0, 8'h15, 1'b0, 1'b1};
    vecs[4] = '{5,  2'd1, 1'b1, 1'b1, 1'b0, 8'h2A, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0};
    vecs[5] = '{7,  2'd3, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{16, 2'd3, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1};
    vecs[7] = '{4,  2'd1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h3F, 1'b0, 1'b0};
    vecs[8] = '{9,  2'd0, 1'b1, 1'b0, 1'b0, 8'h0B, 1'b1, 1'b1, 1'b1, 8'h0B, 1'b0, 1'b0};
    vecs[9] = '{16, 2'd3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};

    // Reset values
    cycles(3);
    check("rst_valid", 32'(rx_valid_o), 32'd0);
    check("rst_data",  32'(rx_data_o),  32'd0);
    check("rst_perr",  32'(rx_perr_o),  32'd0);
    check("rst_ferr",  32'(rx_ferr_o),  32'd0);
    check("rst_ovr",   32'(overrun_o),  32'd0);
    check("rst_brk",   32'(break_o),    32'd0);
    check("rst_count", 32'(fifo_count_o), 32'd0);
    rst_i = 1'b0;
    cycles(5);

    // 8N1 0xA5 held at the head until popped
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    send_frame(16, 2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);
    cycles(50);
    check("hold_valid", 32'(rx_valid_o), 32'd1);
    check("hold_data",  32'(rx_data_o),  32'hA5);
    check("hold_count", 32'(fifo_count_o), 32'd1);
    rx_ready_i = 1'b1;
    cycles(3);
    check("hold_popped", 32'(rx_valid_o), 32'd0);

    // Table of frames, drained as they arrive
    foreach (vecs[k]) begin
      exp_q.push_back({vecs[k].ed, vecs[k].ep, vecs[k].ef});
      send_frame(vecs[k].cpb, vecs[k].db, vecs[k].pen, vecs[k].podd, vecs[k].st2,
                 vecs[k].d, vecs[k].pb, vecs[k].s1, vecs[k].s2);
    end
    cycles(5);
    check("table_drained", 32'(exp_q.size()), 32'd0);

    // Break: line low for 12 bit times gives one 0x00/ferr entry and one pulse
    b0 = brk_cnt;
    set_cfg(16, 2'd3, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({8'h00, 1'b0, 1'b1});
    drive_bit(1'b0, 12 * 16);
    drive_bit(1'b1, 32);
    check("break_pulses", 32'(brk_cnt - b0), 32'd1);
    check("break_drained", 32'(exp_q.size()), 32'd0);
    exp_q.push_back({8'h5A, 1'b0, 1'b0});
    send_frame(16, 2'd3, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1);
    cycles(3);
    check("after_break", 32'(exp_q.size()), 32'd0);

    // Overrun: five frames into a 4-deep FIFO with no pops
    rx_ready_i = 1'b0;
    o0 = ovr_cnt;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back({8'(v), 1'b0, 1'b0});
      send_frame(16, 2'd3, 1'b0, 1'b0, 1'b0, 8'(v), 1'b0, 1'b1, 1'b1);
    end
    check("ovr_count", 32'(fifo_count_o), 32'd4);
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_head", 32'(rx_data_o), 32'h01);
    rx_ready_i = 1'b1;
    cycles(8);
    check("ovr_empty", 32'(rx_valid_o), 32'd0);
    check("ovr_drained", 32'(exp_q.size()), 32'd0);

    // Glitch: 4-cycle low pulse yields nothing; next frame is received
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    check("glitch_count", 32'(fifo_count_o), 32'd0);
    exp_q.push_back({8'h33, 1'b0, 1'b0});
    send_frame(16, 2'd3, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b1);
    cycles(3);
    check("glitch_next", 32'(exp_q.size()), 32'd0);

    // Reset in mid-frame flushes the FIFO and the partial character
    rx_ready_i = 1'b0;
    exp_q.push_back({8'h77, 1'b0, 1'b0});
    send_frame(16, 2'd3, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 1'b1);
    check("pre_rst_count", 32'(fifo_count_o), 32'd1);
    set_cfg(16, 2'd3, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 20);
    rst_i = 1'b1;
    cycles(1);
    rst_i = 1'b0;
    exp_q.delete();
    check("mrst_valid", 32'(rx_valid_o), 32'd0);
    check("mrst_data",  32'(rx_data_o),  32'd0);
    check("mrst_flags", 32'({rx_perr_o, rx_ferr_o, overrun_o, break_o}), 32'd0);
    check("mrst_count", 32'(fifo_count_o), 32'd0);
    cycles(200);
    check("mrst_no_entry", 32'(fifo_count_o), 32'd0);
    rx_ready_i = 1'b1;
    cycles(2);

    check("total_breaks", 32'(brk_cnt), 32'd1);
    check("total_overruns", 32'(ovr_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
